button_reset_sequencer: RTL and testbench

- Turns a raw, bouncy, active-high push-button into a controlled system-reset sequence.
- A press is debounced and its duration classified: short press = plain soft reset, long press = reset into bootloader.
- Sequence per event: ask the CPU/bus side to quiesce, wait for an ack or a timeout, hold the system reset for a fixed time, then enforce a cooldown.
- Sits between the board button pin and the SoC reset/boot-mode logic.

---
 rtl/button_reset_sequencer.sv | 171 +++++++++++++++++
 tb/tb_button_reset_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : button_reset_sequencer
// Brief    : Debounces a push-button, classifies short/long presses and runs a
//            quiesce -> reset-hold -> cooldown system reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module button_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SHORT_CYCLES    = 10,
    parameter int LONG_CYCLES     = 50,
    parameter int QUIESCE_TIMEOUT = 20,
    parameter int RST_HOLD_CYCLES = 8,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_quiesce_ack,
    output logic o_quiesce_req,
    output logic o_sys_rst,
    output logic o_boot_mode,
    output logic o_timeout,
    output logic o_busy
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_PR_W  = $clog2(LONG_CYCLES + 1);
    localparam int c_TMR_MAX_I =
        (QUIESCE_TIMEOUT > RST_HOLD_CYCLES) ?
            ((QUIESCE_TIMEOUT > COOLDOWN_CYCLES) ? QUIESCE_TIMEOUT : COOLDOWN_CYCLES) :
            ((RST_HOLD_CYCLES > COOLDOWN_CYCLES) ? RST_HOLD_CYCLES : COOLDOWN_CYCLES);
    localparam int c_TMR_W = $clog2(c_TMR_MAX_I + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_PR_W-1:0]  c_SHORT     = c_PR_W'(SHORT_CYCLES);
    localparam logic [c_PR_W-1:0]  c_LONG      = c_PR_W'(LONG_CYCLES);
    localparam logic [c_TMR_W-1:0] c_REQ_LAST  = c_TMR_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_COOL_LAST = c_TMR_W'(COOLDOWN_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX   = c_TMR_W'(c_TMR_MAX_I);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_HOLD     = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync1;
    logic                r_btn_s;
    logic                r_btn_d;
    logic                r_btn_d_q;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_PR_W-1:0]   r_press;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_quiesce_req;
    logic                r_sys_rst;
    logic                r_boot_mode;
    logic                r_timeout;
    logic                r_busy;
    logic                w_fall;
    logic                w_boot_nxt;
    logic                w_timeout_nxt;

    assign w_fall = r_btn_d_q & ~r_btn_d;

    // Synchronizer, debouncer and press-duration counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_btn_s   <= 1'b0;
            r_btn_d   <= 1'b0;
            r_btn_d_q <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_btn_s   <= r_sync1;
            r_btn_d_q <= r_btn_d;
            if (r_btn_s != r_btn_d) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_btn_d  <= r_btn_s;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
            // Presses only count toward an event while idle.
            if ((r_state != S_IDLE) || !r_btn_d) begin
                r_press <= '0;
            end else if (r_press != c_LONG) begin
                r_press <= r_press + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_boot_nxt    = r_boot_mode;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && (r_press >= c_LONG)) begin
                    w_boot_nxt  = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (w_fall && (r_press >= c_SHORT)) begin
                    w_boot_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the final cycle takes priority over the timeout.
                if (i_quiesce_ack) begin
                    w_state_nxt = S_HOLD;
                end else if (r_timer == c_REQ_LAST) begin
                    w_state_nxt   = S_HOLD;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_timer == c_HOLD_LAST) begin
                    w_state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if ((r_timer >= c_COOL_LAST) && !r_btn_d) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One timer serves every state; it restarts on each state change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_quiesce_req <= 1'b0;
            r_sys_rst     <= 1'b0;
            r_boot_mode   <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_timer != c_TMR_MAX) begin
                r_timer <= r_timer + 1'b1;
            end
            r_quiesce_req <= (w_state_nxt == S_REQ);
            r_sys_rst     <= (w_state_nxt == S_HOLD);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_boot_mode   <= w_boot_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign o_quiesce_req = r_quiesce_req;
    assign o_sys_rst     = r_sys_rst;
    assign o_boot_mode   = r_boot_mode;
    assign o_timeout     = r_timeout;
    assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_button_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_reset_sequencer
// Brief    : Scoreboard bench: each expected reset sequence is queued by the
//            stimulus and checked by a monitor when the DUT completes it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_reset_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic btn   = 1'b0;
    logic ack   = 1'b0;
    logic quiesce_req, sys_rst, boot_mode, timeout, busy;

    int cyc         = 0;
    int fall_cyc    = 0;
    int vectors     = 0;
    int miscompares = 0;
    int seq_seen    = 0;

    typedef struct {
        logic boot;
        int   lat;
        int   req;
        int   tmo;
        int   hold;
        int   cool;
    } exp_t;

    exp_t exp_q[$];

    button_reset_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn         (btn),
        .i_quiesce_ack (ack),
        .o_quiesce_req (quiesce_req),
        .o_sys_rst     (sys_rst),
        .o_boot_mode   (boot_mode),
        .o_timeout     (timeout),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return quiesce_req;
            1:       return sys_rst;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int n = 0;
        while (!cond(which) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached"}, int'(cond(which)), 1);
    endtask

    // Monitor: measures each busy window and compares against the queue head.
    int   m_lat, m_req, m_tf, m_ta, m_hold, m_cool;
    logic m_boot;
    bit   m_in_seq = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_in_seq = 1'b0;
            end else begin
                if (!m_in_seq && busy) begin
                    m_in_seq = 1'b1;
                    m_lat  = cyc - fall_cyc;
                    m_boot = boot_mode;
                    m_req = 0; m_tf = 0; m_ta = 0; m_hold = 0; m_cool = 0;
                end
                if (m_in_seq && busy) begin
                    if (timeout) begin
                        m_ta++;
                        if (sys_rst && m_hold == 0) m_tf++;
                    end
                    if (quiesce_req)  m_req++;
                    else if (sys_rst) m_hold++;
                    else              m_cool++;
                end else if (m_in_seq) begin
                    m_in_seq = 1'b0;
                    seq_seen++;
                    check("seq_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("latency",       m_lat,       e.lat);
                        check("boot_mode",     int'(m_boot), int'(e.boot));
                        check("req_len",       m_req,       e.req);
                        check("timeout_first", m_tf,        e.tmo);
                        check("timeout_total", m_ta,        e.tmo);
                        check("hold_len",      m_hold,      e.hold);
                        check("cool_len",      m_cool,      e.cool);
                    end
                end
            end
        end
    end

    // Press for n cycles; ack_at = REQ cycle in which ack rises (0 = never).
    task automatic press(input int n, input int ack_at, input bit evt, input bit push,
                         input logic e_boot, input int e_req, input int e_tmo, input int e_cool);
        exp_t e;
        if (push) begin
            e.boot = e_boot; e.lat = 7; e.req = e_req;
            e.tmo = e_tmo; e.hold = 8; e.cool = e_cool;
            exp_q.push_back(e);
        end
        @(negedge clk);
        btn = 1'b1;
        repeat (n) @(negedge clk);
        btn = 1'b0;
        fall_cyc = cyc;
        if (evt) begin
            if (ack_at == 1) begin
                ack = 1'b1;
            end else if (ack_at > 1) begin
                wait_for(0, "req");
                repeat (ack_at - 1) @(negedge clk);
                ack = 1'b1;
            end
            wait_for(1, "hold");
            ack = 1'b0;
        end
    endtask

    task automatic settle(input string name);
        wait_for(2, name);
        repeat (5) @(negedge clk);
    endtask

    initial begin : stimulus
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quiesce_req", int'(quiesce_req), 0);
        check("rst_sys_rst",     int'(sys_rst),     0);
        check("rst_boot_mode",   int'(boot_mode),   0);
        check("rst_timeout",     int'(timeout),     0);
        check("rst_busy",        int'(busy),        0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Short press, ack in 3rd REQ cycle
        press(20, 3, 1'b1, 1'b1, 1'b0, 3, 0, 16);
        settle("t1_idle");

        // Long press, no ack: timeout path
        press(60, 0, 1'b1, 1'b1, 1'b1, 20, 1, 16);
        settle("t2_idle");

        // Glitches and a sub-threshold press
        repeat (3) begin
            @(negedge clk);
            btn = 1'b1;
            repeat (3) @(negedge clk);
            btn = 1'b0;
            repeat (10) @(negedge clk);
        end
        check("glitch_busy", int'(busy), 0);
        press(8, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("short8_busy", int'(busy),        0);
        check("short8_req",  int'(quiesce_req), 0);

        // Ack high on entry; re-press from HOLD held 100 cycles
        press(20, 1, 1'b1, 1'b1, 1'b0, 1, 0, 99);
        btn = 1'b1;
        repeat (100) @(negedge clk);
        btn = 1'b0;
        settle("t4_idle");
        repeat (20) @(negedge clk);
        check("t4_no_second_event", int'(busy), 0);

        // Ack on the last REQ cycle beats the timeout
        press(20, 20, 1'b1, 1'b1, 1'b0, 20, 0, 16);
        settle("t5_idle");

        // Reset mid-HOLD aborts the sequence
        press(60, 1, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        check("pre_rst_boot_mode", int'(boot_mode), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sys_rst",     int'(sys_rst),     0);
        check("abort_busy",        int'(busy),        0);
        check("abort_boot_mode",   int'(boot_mode),   0);
        check("abort_quiesce_req", int'(quiesce_req), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_abort_busy", int'(busy), 0);

        // Exact press-length thresholds
        press(10, 2, 1'b1, 1'b1, 1'b0, 2, 0, 16);
        settle("t6a_idle");
        press(50, 2, 1'b1, 1'b1, 1'b1, 2, 0, 16);
        settle("t6b_idle");
        press(9, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("press9_busy",      int'(busy),      0);
        check("boot_mode_held",   int'(boot_mode), 1);

        check("sequence_count", seq_seen, 6);
        check("queue_drained",  exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
